// File: rtl/dm_lsu.sv
// Load/store unit in front of the word-organised data memory: byte/half/word access, sub-word RMW stores.
// Optional build macro MISALIGN_CHK_EN: flag misaligned half/word requests instead of forcing alignment.
module dm_lsu #(
  parameter int unsigned DM_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic [31:0]      dm_wd,
  input  logic [31:0]      dm_rd
);

  localparam int unsigned AW = DM_AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE_WR, S_RESP} state_t;

  state_t        r_state, w_next;
  logic          r_ready, r_resp_valid, r_resp_err;
  logic [31:0]   r_resp_rdata;
  logic          r_we, r_unsigned, r_mis;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_merged;

  logic          w_accept, w_req_word, w_req_half, w_req_mis;
  logic [AW-1:0] w_req_addr;
  logic          w_unused_addr;
  logic [4:0]    w_bsh, w_hsh;
  logic [31:0]   w_byte_mask, w_half_mask, w_load, w_merged;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_dm_we;
  logic [31:0]   w_dm_wd;

  assign w_accept      = (r_state == S_IDLE) && r_ready && req_valid;
  assign w_req_word    = req_size[1];
  assign w_req_half    = (req_size == 2'b01);
  assign w_unused_addr = ^req_addr[31:AW];

`ifdef MISALIGN_CHK_EN
  assign w_req_mis  = (w_req_half && req_addr[0]) || (w_req_word && (req_addr[1:0] != 2'b00));
  assign w_req_addr = req_addr[AW-1:0];
`else
  assign w_req_mis  = 1'b0;
  // Silently align half/word requests by dropping the offending low bits
  always_comb begin
    w_req_addr = req_addr[AW-1:0];
    if (w_req_word)      w_req_addr[1:0] = 2'b00;
    else if (w_req_half) w_req_addr[0]   = 1'b0;
  end
`endif

  // Little-endian lane selection and extension / merge
  assign w_bsh       = {r_addr[1:0], 3'b000};
  assign w_hsh       = {r_addr[1], 4'b0000};
  assign w_byte_mask = 32'h0000_00FF << w_bsh;
  assign w_half_mask = 32'h0000_FFFF << w_hsh;
  assign w_byte      = 8'(dm_rd >> w_bsh);
  assign w_half      = 16'(dm_rd >> w_hsh);
  assign w_merged    = r_size[0] ? ((dm_rd & ~w_half_mask) | (32'(r_wdata[15:0]) << w_hsh))
                                 : ((dm_rd & ~w_byte_mask) | (32'(r_wdata[7:0]) << w_bsh));

  always_comb begin
    w_load = dm_rd;
    case (r_size)
      2'b00:   w_load = r_unsigned ? 32'(w_byte) : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? 32'(w_half) : {{16{w_half[15]}}, w_half};
      default: w_load = dm_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_dm_we = 1'b0;
    w_dm_wd = r_wdata;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_ACCESS;
      S_ACCESS: begin
        if (r_mis || !r_we) begin
          w_next = S_RESP;
        end else if (r_size[1]) begin
          w_dm_we = 1'b1;
          w_next  = S_RESP;
        end else begin
          w_next = S_MERGE_WR;
        end
      end
      S_MERGE_WR: begin
        w_dm_we = 1'b1;
        w_dm_wd = r_merged;
        w_next  = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset must never let a half-finished operation write memory
  assign dm_we   = w_dm_we & ~reset;
  assign dm_wd   = w_dm_wd;
  assign dm_addr = r_addr[AW-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_ready      <= (w_next == S_IDLE);
      r_resp_valid <= (w_next == S_RESP);
      if (r_state == S_ACCESS) begin
        r_resp_err <= r_mis;
        if (r_mis)      r_resp_rdata <= '0;
        else if (!r_we) r_resp_rdata <= w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= w_req_addr;
      r_wdata    <= req_wdata;
      r_mis      <= w_req_mis;
    end
    if (r_state == S_ACCESS) r_merged <= w_merged;
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: directed scenarios plus random traffic against an array-based memory model.
module tb_dm_lsu;
  localparam int unsigned DM_AW = 5;
  localparam int unsigned DEPTH = 32;

  logic             clk;
  logic             reset;
  logic             req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic             resp_valid, resp_err;
  logic [31:0]      resp_rdata;
  logic [DM_AW-1:0] dm_addr;
  logic             dm_we;
  logic [31:0]      dm_wd, dm_rd;

  dm_lsu #(.DM_AW(DM_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the unit, with write bookkeeping
  logic [31:0]      dm_mem [DEPTH];
  int               we_cnt = 0;
  logic [DM_AW-1:0] last_wa = '0;
  logic [31:0]      last_wd = '0;
  assign dm_rd = dm_mem[dm_addr];
  always @(posedge clk) begin
    if (dm_we) begin
      dm_mem[dm_addr] <= dm_wd;
      we_cnt          <= we_cnt + 1;
      last_wa         <= dm_addr;
      last_wd         <= dm_wd;
    end
  end

  logic [31:0] ref_mem [DEPTH];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_CHK_EN
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_CHK_EN
    return a;
`else
    if (sz >= 2'd2) return a - (a % 4);
    if (sz == 2'd1) return a - (a % 2);
    return a;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    if (sz == 2'd0) begin
      m = 32'd255 << (8 * (a % 4));
      return (old & ~m) | ((wd % 256) << (8 * (a % 4)));
    end else if (sz == 2'd1) begin
      m = 32'd65535 << (16 * ((a / 2) % 2));
      return (old & ~m) | ((wd % 65536) << (16 * ((a / 2) % 2)));
    end
    return wd;
  endfunction

  // One complete request; entered and left on a falling edge with the unit idle
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] ea, exp_rd;
    bit          mis;
    int          idx, exp_lat, exp_we, lat, we0;
    ea      = eff_addr(a, sz);
    mis     = is_mis(a, sz);
    idx     = int'((ea / 4) % DEPTH);
    exp_rd  = mis ? 32'd0 : model_load(ref_mem[idx], ea, sz, uns);
    exp_lat = (we && !mis && sz < 2'd2) ? 3 : 2;
    exp_we  = (we && !mis) ? 1 : 0;
    if (we && !mis) ref_mem[idx] = model_store(ref_mem[idx], ea, sz, wd);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    we0          = we_cnt;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    last_rd  = resp_rdata;
    last_err = resp_err;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(resp_err), 32'(mis));
    if (!we) chk({tag, "_rdata"}, resp_rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  initial begin
    int          we0;
    logic [31:0] saved;
    logic [1:0]  sz;

    // Reset with a request held: it must not be taken while req_ready is low
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_not_taken", 32'(we_cnt), 32'd0);

    for (int i = 0; i < int'(DEPTH); i++) do_op(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "fill");

    // 1: word store / load
    do_op(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF, "t1_st");
    chk("t1_wa", 32'(last_wa), 32'd2);
    chk("t1_wd", last_wd, 32'hDEAD_BEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, "t1_ld");
    chk("t1_ld_val", last_rd, 32'hDEAD_BEEF);

    // 2: byte RMW and extension
    do_op(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AA, "t2_st");
    chk("t2_mem", dm_mem[2], 32'hDEAD_AAEF);
    do_op(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, "t2_lds");
    chk("t2_lds_val", last_rd, 32'hFFFF_FFAA);
    do_op(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, "t2_ldu");
    chk("t2_ldu_val", last_rd, 32'h0000_00AA);

    // 3: half RMW and extension
    do_op(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_1234, "t3_st");
    chk("t3_mem", dm_mem[2], 32'h1234_AAEF);
    do_op(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, "t3_lds");
    chk("t3_lds_val", last_rd, 32'h0000_1234);
    do_op(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_8001, "t3_st2");
    do_op(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, "t3_lds2");
    chk("t3_lds2_val", last_rd, 32'hFFFF_8001);

    // 4: address wrap modulo depth
    do_op(1'b1, 2'd2, 1'b0, 32'h80, 32'h5, "t4_st");
    chk("t4_wa", 32'(last_wa), 32'd0);
    do_op(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, "t4_ld");
    chk("t4_ld_val", last_rd, 32'h5);

    // 5: misaligned word load
    do_op(1'b0, 2'd2, 1'b0, 32'h0D, 32'h0, "t5_ld");
`ifdef MISALIGN_CHK_EN
    chk("t5_err", 32'(last_err), 32'd1);
    chk("t5_rd", last_rd, 32'd0);
`else
    chk("t5_err", 32'(last_err), 32'd0);
    chk("t5_rd", last_rd, ref_mem[3]);
`endif

    // 6: reset during the merge write
    saved        = ref_mem[4];
    we0          = we_cnt;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h11;
    req_wdata    = 32'h5A;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_we_merge", 32'(dm_we), 32'd1);
    reset = 1'b1;
    #1 chk("t6_we_gated", 32'(dm_we), 32'd0);
    @(negedge clk);
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_no_write", 32'(we_cnt - we0), 32'd0);
    chk("t6_mem", dm_mem[4], saved);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom, "rnd");
    end
    for (int i = 0; i < int'(DEPTH); i++) chk("final_mem", dm_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
